// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC, in-order imem requests, response FIFO to decode,
// and branch redirect with flush of stale in-flight responses.
module instr_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [6:0]      id_opcode,
  input  logic            id_ready
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = CW + 1;
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] tag_q [DEPTH];
  logic [XLEN-1:0] tag_d [DEPTH];
  logic [XLEN-1:0] instr_q [DEPTH];
  logic [XLEN-1:0] instr_d [DEPTH];
  logic [XLEN-1:0] fpc_q [DEPTH];
  logic [XLEN-1:0] fpc_d [DEPTH];
  logic            req_valid_q, req_valid_d;
  logic            id_valid_q, id_valid_d;

  logic            req_fire, rsp_fire, pop;
  logic [IW-1:0]   push_idx, tag_idx;
  logic [SW-1:0]   occ_d;

  // Next-state: redirect dominates; FIFO and tag queue are shift registers with head at index 0
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    outst_d  = outst_q;
    cnt_d    = cnt_q;
    tag_d    = tag_q;
    instr_d  = instr_q;
    fpc_d    = fpc_q;
    push_idx = '0;
    tag_idx  = '0;
    req_fire = req_valid_q && imem_req_ready;
    rsp_fire = imem_rsp_valid && (outst_q != '0);
    pop      = id_valid_q && id_ready;

    if (redirect_valid) begin
      // every in-flight request, including one accepted now, becomes stale
      pc_d    = redirect_pc;
      cnt_d   = '0;
      outst_d = outst_q + CW'(req_fire) - CW'(rsp_fire);
      state_d = (outst_d != '0) ? FLUSH : RUN;
    end else if (state_q == RUN) begin
      if (pop) begin
        for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
          instr_d[IW'(i)] = instr_q[IW'(i + 1)];
          fpc_d[IW'(i)]   = fpc_q[IW'(i + 1)];
        end
      end
      if (rsp_fire) begin
        push_idx          = IW'(cnt_q - CW'(pop));
        instr_d[push_idx] = imem_rsp_data;
        fpc_d[push_idx]   = tag_q[0];
        for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
          tag_d[IW'(i)] = tag_q[IW'(i + 1)];
        end
      end
      if (req_fire) begin
        tag_idx        = IW'(outst_q - CW'(rsp_fire));
        tag_d[tag_idx] = pc_q;
        pc_d           = pc_q + XLEN'(4);
      end
      cnt_d   = cnt_q + CW'(rsp_fire) - CW'(pop);
      outst_d = outst_q + CW'(req_fire) - CW'(rsp_fire);
    end else begin
      outst_d = outst_q - CW'(rsp_fire);
      if (outst_d == '0) begin
        state_d = RUN;
      end
    end

    occ_d       = SW'(outst_d) + SW'(cnt_d);
    req_valid_d = (state_d == RUN) && (occ_d < SW'(DEPTH));
    id_valid_d  = (cnt_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      outst_q     <= '0;
      cnt_q       <= '0;
      req_valid_q <= 1'b0;
      id_valid_q  <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tag_q[IW'(i)]   <= '0;
        instr_q[IW'(i)] <= '0;
        fpc_q[IW'(i)]   <= '0;
      end
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      outst_q     <= outst_d;
      cnt_q       <= cnt_d;
      req_valid_q <= req_valid_d;
      id_valid_q  <= id_valid_d;
      tag_q       <= tag_d;
      instr_q     <= instr_d;
      fpc_q       <= fpc_d;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign id_valid       = id_valid_q;
  assign id_instr       = instr_q[0];
  assign id_pc          = fpc_q[0];
  assign id_opcode      = instr_q[0][6:0];

`ifndef SYNTHESIS
  // A response with nothing outstanding is a memory protocol violation
  rsp_without_req: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (outst_q != '0))
    else $error("imem response with no outstanding request");
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: queue-based memory/decoder model checked every cycle,
// plus literal expectations for in-order fetch, stall, redirect, PC wrap and async reset.
module tb_instr_fetch_unit;

  localparam int unsigned DEPTH = 2;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [31:0] id_instr, id_pc;
  logic [6:0]  id_opcode;

  logic        b_req_valid, b_req_ready, b_rsp_valid, b_redirect_valid;
  logic [31:0] b_req_addr, b_rsp_data, b_redirect_pc;
  logic        b_id_valid, b_id_ready;
  logic [31:0] b_id_instr, b_id_pc;
  logic [6:0]  b_id_opcode;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_opcode(id_opcode),
    .id_ready(id_ready)
  );

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .DEPTH(DEPTH)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(b_req_valid), .imem_req_addr(b_req_addr), .imem_req_ready(b_req_ready),
    .imem_rsp_valid(b_rsp_valid), .imem_rsp_data(b_rsp_data),
    .redirect_valid(b_redirect_valid), .redirect_pc(b_redirect_pc),
    .id_valid(b_id_valid), .id_instr(b_id_instr), .id_pc(b_id_pc), .id_opcode(b_id_opcode),
    .id_ready(b_id_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; bit stale; int due; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

  req_t        mem_q[$];
  ent_t        fifo_q[$];
  logic [31:0] exp_pc;
  bit          bubble;
  int          cyc;
  int          total, bad;

  int p_ready, p_idr, p_redir, lat_max;
  bit          force_arm;
  logic [31:0] force_pc;

  logic [31:0] hs_log[$], idpc_log[$], idinstr_log[$];
  logic [31:0] b_pend[$], b_hs_log[$], b_idpc_log[$];
  int          t3_phase;
  bit          t3_hs_got, t3_pop_got;
  logic [31:0] t3_hs, t3_idpc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] pc);
    if (pc == 32'h0) return 32'h0000_0033;
    return {pc[31:7] ^ 25'h15A_5A5A, pc[8:2]};
  endfunction

  function automatic bit stale_any();
    foreach (mem_q[i]) if (mem_q[i].stale) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    mem_q.delete(); fifo_q.delete(); b_pend.delete();
    hs_log.delete(); idpc_log.delete(); idinstr_log.delete();
    exp_pc = 32'h0;
    bubble = 1'b1;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; redirect_valid = 1'b0; id_ready = 1'b0;
    b_rsp_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, imem_req_valid, 0);
    chk({tag, "_req_addr"},  imem_req_addr, 32'h0);
    chk({tag, "_id_valid"},  id_valid, 0);
    chk({tag, "_id_instr"},  id_instr, 32'h0);
    chk({tag, "_id_pc"},     id_pc, 32'h0);
    chk({tag, "_id_opcode"}, id_opcode, 0);
    chk({tag, "_wrap_addr"}, b_req_addr, 32'hFFFF_FFFC);
    chk({tag, "_wrap_valid"}, b_req_valid, 0);
  endtask

  // One cycle: compare at negedge, pick inputs, advance the model, drive, move to next negedge
  task automatic step();
    bit exp_rv, rdy, rsp, idr, redir, req_f, pop_f, dut_hs, dut_pop;
    logic [31:0] rpc, rdata;
    req_t h;

    exp_rv = !bubble && !stale_any() && (mem_q.size() + fifo_q.size() < DEPTH);
    chk("req_valid", imem_req_valid, exp_rv);
    chk("req_addr", imem_req_addr, exp_pc);
    chk("id_valid", id_valid, fifo_q.size() != 0);
    if (fifo_q.size() != 0) begin
      chk("id_pc", id_pc, fifo_q[0].pc);
      chk("id_instr", id_instr, fifo_q[0].instr);
      chk("id_opcode", id_opcode, fifo_q[0].instr[6:0]);
    end

    rdy   = ($urandom_range(99) < p_ready);
    rsp   = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
    idr   = ($urandom_range(99) < p_idr);
    redir = ($urandom_range(99) < p_redir);
    rpc   = 32'($urandom()) & 32'hFFFF_FFFC;
    if (force_arm && mem_q.size() == 2 && !stale_any()) begin
      redir = 1'b1; rpc = force_pc; force_arm = 1'b0; t3_phase = 2;
    end else if (t3_phase == 2) begin
      redir = 1'b0;
    end
    rdata = rsp ? data_of(mem_q[0].pc) : 32'($urandom());

    dut_hs  = imem_req_valid && rdy && !redir;
    dut_pop = id_valid && idr && !redir;
    if (dut_hs) hs_log.push_back(imem_req_addr);
    if (dut_pop) begin
      idpc_log.push_back(id_pc);
      idinstr_log.push_back(id_instr);
    end
    if (t3_phase == 2 && !redir) begin
      if (dut_hs && !t3_hs_got) begin t3_hs = imem_req_addr; t3_hs_got = 1'b1; end
      if (dut_pop && !t3_pop_got) begin t3_idpc = id_pc; t3_pop_got = 1'b1; end
    end

    req_f = exp_rv && rdy;
    pop_f = (fifo_q.size() != 0) && idr;
    if (redir) begin
      foreach (mem_q[i]) mem_q[i].stale = 1'b1;
      if (rsp) void'(mem_q.pop_front());
      if (req_f) mem_q.push_back('{pc: exp_pc, stale: 1'b1, due: cyc + $urandom_range(lat_max, 1)});
      fifo_q.delete();
      exp_pc = rpc;
    end else begin
      if (pop_f) void'(fifo_q.pop_front());
      if (rsp) begin
        h = mem_q.pop_front();
        if (!h.stale) fifo_q.push_back('{pc: h.pc, instr: data_of(h.pc)});
      end
      if (req_f) begin
        mem_q.push_back('{pc: exp_pc, stale: 1'b0, due: cyc + $urandom_range(lat_max, 1)});
        exp_pc = exp_pc + 32'd4;
      end
    end

    // wrap instance: always ready, responds one cycle after each accept
    b_rsp_valid = 1'b0;
    b_rsp_data  = 32'h0;
    if (b_pend.size() != 0) begin
      b_rsp_valid = 1'b1;
      b_rsp_data  = data_of(b_pend.pop_front());
    end
    if (b_req_valid) begin
      b_pend.push_back(b_req_addr);
      if (b_hs_log.size() < 4) b_hs_log.push_back(b_req_addr);
    end
    if (b_id_valid && b_idpc_log.size() < 4) b_idpc_log.push_back(b_id_pc);

    imem_req_ready = rdy;
    imem_rsp_valid = rsp;
    imem_rsp_data  = rdata;
    redirect_valid = redir;
    redirect_pc    = rpc;
    id_ready       = idr;
    bubble = 1'b0;
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_knobs(input int rd, input int ir, input int rr, input int lm);
    p_ready = rd; p_idr = ir; p_redir = rr; lat_max = lm;
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    force_arm = 1'b0; force_pc = 32'h100; t3_phase = 0; t3_hs_got = 1'b0; t3_pop_got = 1'b0;
    t3_hs = 32'h0; t3_idpc = 32'h0;
    rst_n = 1'b1;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;
    b_req_ready = 1'b1; b_rsp_valid = 1'b0; b_rsp_data = 32'h0;
    b_redirect_valid = 1'b0; b_redirect_pc = 32'h0; b_id_ready = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("rst0");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // in-order streaming with single-cycle memory
    set_knobs(100, 100, 0, 1);
    repeat (20) step();
    chk("p1_hs_cnt", hs_log.size() >= 3, 1);
    chk("p1_pop_cnt", idpc_log.size() >= 3, 1);
    if (hs_log.size() >= 3) begin
      chk("p1_hs0", hs_log[0], 32'h0);
      chk("p1_hs1", hs_log[1], 32'h4);
      chk("p1_hs2", hs_log[2], 32'h8);
    end
    if (idpc_log.size() >= 3) begin
      chk("p1_idpc0", idpc_log[0], 32'h0);
      chk("p1_idpc1", idpc_log[1], 32'h4);
      chk("p1_idpc2", idpc_log[2], 32'h8);
      chk("p1_instr0", idinstr_log[0], 32'h0000_0033);
      chk("p1_opcode0", idinstr_log[0] & 32'h7F, 32'h33);
    end

    // wrap-around instance has had plenty of cycles by now
    chk("wrap_hs_cnt", b_hs_log.size() >= 3, 1);
    chk("wrap_pop_cnt", b_idpc_log.size() >= 2, 1);
    if (b_hs_log.size() >= 3) begin
      chk("wrap_hs0", b_hs_log[0], 32'hFFFF_FFFC);
      chk("wrap_hs1", b_hs_log[1], 32'h0000_0000);
      chk("wrap_hs2", b_hs_log[2], 32'h0000_0004);
    end
    if (b_idpc_log.size() >= 2) begin
      chk("wrap_idpc0", b_idpc_log[0], 32'hFFFF_FFFC);
      chk("wrap_idpc1", b_idpc_log[1], 32'h0000_0000);
    end

    // decode stall fills the FIFO and throttles requests
    set_knobs(100, 0, 0, 1);
    repeat (12) step();
    chk("stall_req_valid", imem_req_valid, 0);
    chk("stall_id_valid", id_valid, 1);
    set_knobs(100, 100, 0, 1);
    repeat (10) step();

    // redirect with two requests in flight
    set_knobs(100, 100, 0, 3);
    force_arm = 1'b1; t3_phase = 1;
    repeat (40) step();
    chk("redir_taken", t3_phase, 2);
    chk("redir_hs_seen", t3_hs_got, 1);
    chk("redir_pop_seen", t3_pop_got, 1);
    chk("redir_first_addr", t3_hs, 32'h100);
    chk("redir_first_idpc", t3_idpc, 32'h100);
    force_arm = 1'b0; t3_phase = 0;

    // broad random traffic
    for (int k = 0; k < 3000; k++) begin
      set_knobs(70, 60, 4, 1 + (k / 500) % 4);
      step();
    end

    // reach a flush with stale requests outstanding, then reset asynchronously
    set_knobs(100, 50, 30, 4);
    for (int k = 0; k < 300 && !stale_any(); k++) step();
    chk("flush_reached", stale_any(), 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_mid");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    set_knobs(80, 70, 4, 2);
    repeat (300) step();
    chk("post_rst_hs_cnt", hs_log.size() != 0, 1);
    if (hs_log.size() != 0) chk("post_rst_first_addr", hs_log[0], 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
